// File: rtl/cpu_pkg.sv
// Shared VeriRISC definitions: opcode encodings, sequencer phases and default opcode width.
package cpu_pkg;

    localparam int OPCODE_WIDTH = 3;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

endpackage

// File: rtl/controller_if.sv
// Sequencer <-> datapath bundle: opcode/flags in, phase and control strobes out.
interface controller_if #(parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    zero;
    logic                    go;
    logic [2:0]              phase;
    logic                    sel;
    logic                    rd;
    logic                    ld_ir;
    logic                    inc_pc;
    logic                    ld_pc;
    logic                    ld_ac;
    logic                    wr;
    logic                    data_e;
    logic                    halt;

    modport master (
        input  opcode, zero, go,
        output phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
    );

    modport slave (
        output opcode, zero, go,
        input  phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
    );
endinterface

// File: rtl/controller.sv
// VeriRISC instruction sequencer: eight-phase fetch/decode/execute loop with halt/resume.
//
//  state      | meaning
//  INST_ADDR  | PC drives memory address
//  INST_FETCH | read instruction
//  INST_LOAD  | load IR
//  IDLE       | IR load held, opcode settles
//  OP_ADDR    | bump PC; HLT parks here while halted
//  OP_FETCH   | read operand for ALU ops
//  ALU_OP     | SKZ skip / JMP load / STO drive bus
//  STORE      | accumulator load, jump or memory write
module controller
    import cpu_pkg::*;
#(
    parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    controller_if.master  bus
);

    phase_e                  phase;
    logic                    halted;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    is_hlt, is_skz, is_sto, is_jmp, is_alu;

    assign opcode = bus.opcode;
    assign is_hlt = (opcode == OPCODE_WIDTH'(HLT));
    assign is_skz = (opcode == OPCODE_WIDTH'(SKZ));
    assign is_sto = (opcode == OPCODE_WIDTH'(STO));
    assign is_jmp = (opcode == OPCODE_WIDTH'(JMP));
    assign is_alu = (opcode == OPCODE_WIDTH'(ADD)) || (opcode == OPCODE_WIDTH'(AND)) ||
                    (opcode == OPCODE_WIDTH'(XOR)) || (opcode == OPCODE_WIDTH'(LDA));

    // A go coinciding with the HLT-decode edge is dropped: halted is not yet set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= INST_ADDR;
            halted <= 1'b0;
        end else if (halted) begin
            if (bus.go) begin
                halted <= 1'b0;
                phase  <= INST_ADDR;
            end
        end else if (phase == OP_ADDR && is_hlt) begin
            halted <= 1'b1;
        end else begin
            phase <= phase_e'(phase + 3'd1);
        end
    end

    logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    // zero feeds the decode directly so SKZ sees the live flag during ALU_OP.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR:  sel = 1'b1;
                INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
                INST_LOAD,
                IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                OP_ADDR:    begin inc_pc = 1'b1; halt = is_hlt; end
                OP_FETCH:   rd = is_alu;
                ALU_OP: begin
                    rd     = is_alu;
                    inc_pc = is_skz && bus.zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = is_alu;
                    ld_ac  = is_alu;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign bus.phase  = phase;
    assign bus.sel    = sel;
    assign bus.rd     = rd;
    assign bus.ld_ir  = ld_ir;
    assign bus.inc_pc = inc_pc;
    assign bus.ld_pc  = ld_pc;
    assign bus.ld_ac  = ld_ac;
    assign bus.wr     = wr;
    assign bus.data_e = data_e;
    assign bus.halt   = halt;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed scenarios plus randomized run against a phase-table model.
module tb_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] op_r;
    logic       zero_r;
    logic       go_r;

    int tests;
    int fails;

    int m_ph;
    bit m_hl;

    controller_if #(.OPCODE_WIDTH(3)) bus ();

    controller #(.OPCODE_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.opcode = op_r;
    assign bus.zero   = zero_r;
    assign bus.go     = go_r;

    // {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    logic [11:0] dut_vec;
    assign dut_vec = {bus.phase, bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                      bus.ld_ac, bus.wr, bus.data_e, bus.halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model_out(int ph, bit hl, logic [2:0] op, logic z);
        bit alu, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
        if (hl) return {3'd4, 9'b0_0000_0001};
        alu    = (op >= 3'd2 && op <= 3'd5);
        sel    = (ph <= 3);
        rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        ld_ir  = (ph == 2 || ph == 3);
        inc_pc = (ph == 4) || (ph == 6 && op == 3'd1 && z);
        ld_pc  = (ph >= 6 && op == 3'd7);
        ld_ac  = (ph == 7 && alu);
        wr     = (ph == 7 && op == 3'd6);
        data_e = (ph >= 6 && op == 3'd6);
        halt   = (ph == 4 && op == 3'd0);
        return {3'(ph), sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
    endfunction

    task automatic model_step();
        if (m_hl) begin
            if (go_r) begin
                m_hl = 1'b0;
                m_ph = 0;
            end
        end else if (m_ph == 4 && op_r == 3'd0) begin
            m_hl = 1'b1;
        end else begin
            m_ph = (m_ph + 1) % 8;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic sync_to_phase0();
        for (int i = 0; i < 16 && !(m_ph == 0 && !m_hl); i++) begin
            if (m_hl) go_r = 1'b1;
            tick();
            go_r = 1'b0;
        end
        if (m_ph != 0 || m_hl) begin
            fails++;
            $display("FAIL sync_timeout phase=%0d halted=%0d required phase=0 halted=0", m_ph, m_hl);
        end
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        rst_n  = 1'b0;
        op_r   = 3'd2;
        zero_r = 1'b0;
        go_r   = 1'b0;
        m_ph   = 0;
        m_hl   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp = model_out(m_ph, m_hl, op_r, zero_r);
        tests++;
        if (dut_vec !== exp) begin
            fails++;
            $display("FAIL reset_state got=%b exp=%b", dut_vec, exp);
        end
        go_r   = 1'b1;
        zero_r = 1'b1;
        @(negedge clk);
        tests++;
        if (dut_vec !== 12'b000_1_0000_0000) begin
            fails++;
            $display("FAIL reset_held got=%b exp=%b", dut_vec, 12'b000_1_0000_0000);
        end
        go_r   = 1'b0;
        zero_r = 1'b0;
        rst_n  = 1'b1;
        tick();
        exp = model_out(m_ph, m_hl, op_r, zero_r);
        tests++;
        if (dut_vec !== exp || bus.phase !== 3'd1) begin
            fails++;
            $display("FAIL reset_first_edge got=%b exp=%b", dut_vec, exp);
        end
    endtask

    task automatic test_add();
        logic [11:0] exp;
        op_r = 3'd2;
        sync_to_phase0();
        zero_r = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            exp = model_out(m_ph, m_hl, op_r, zero_r);
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL add ph=%0d got=%b exp=%b", m_ph, dut_vec, exp);
            end
            if (c < 8) tick();
        end
    endtask

    task automatic test_skz();
        logic [11:0] exp;
        int pulses;
        for (int z = 1; z >= 0; z--) begin
            op_r = 3'd2;
            sync_to_phase0();
            op_r   = 3'd1;
            zero_r = z[0];
            pulses = 0;
            for (int c = 0; c < 8; c++) begin
                exp = model_out(m_ph, m_hl, op_r, zero_r);
                tests++;
                if (dut_vec !== exp) begin
                    fails++;
                    $display("FAIL skz z=%0d ph=%0d got=%b exp=%b", z, m_ph, dut_vec, exp);
                end
                if (bus.inc_pc === 1'b1) pulses++;
                tick();
            end
            tests++;
            if (pulses != (z ? 2 : 1)) begin
                fails++;
                $display("FAIL skz_inc_pc_count z=%0d got=%0d exp=%0d", z, pulses, z ? 2 : 1);
            end
        end
    endtask

    task automatic test_sto_jmp();
        logic [11:0] exp;
        for (int k = 6; k <= 7; k++) begin
            op_r = 3'd2;
            sync_to_phase0();
            op_r = 3'(k);
            for (int c = 0; c < 8; c++) begin
                zero_r = 1'($urandom_range(0, 1));
                #1;
                exp = model_out(m_ph, m_hl, op_r, zero_r);
                tests++;
                if (dut_vec !== exp) begin
                    fails++;
                    $display("FAIL sto_jmp op=%0d ph=%0d got=%b exp=%b", k, m_ph, dut_vec, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_halt();
        logic [11:0] exp;
        op_r = 3'd2;
        sync_to_phase0();
        op_r   = 3'd0;
        zero_r = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        // go during the HLT-decode edge must be lost
        go_r = 1'b1;
        exp = model_out(m_ph, m_hl, op_r, zero_r);
        tests++;
        if (dut_vec !== exp) begin
            fails++;
            $display("FAIL halt_decode got=%b exp=%b", dut_vec, exp);
        end
        tick();
        go_r = 1'b0;
        for (int c = 0; c < 10; c++) begin
            op_r   = 3'($urandom_range(0, 7));
            zero_r = 1'($urandom_range(0, 1));
            #1;
            exp = model_out(m_ph, m_hl, op_r, zero_r);
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL halted_hold c=%0d got=%b exp=%b", c, dut_vec, exp);
            end
            tick();
        end
        go_r = 1'b1;
        tick();
        go_r = 1'b0;
        exp = model_out(m_ph, m_hl, op_r, zero_r);
        tests++;
        if (dut_vec !== exp || bus.phase !== 3'd0) begin
            fails++;
            $display("FAIL resume got=%b exp=%b", dut_vec, exp);
        end
        // reset while halted
        op_r = 3'd0;
        for (int c = 0; c < 12 && !m_hl; c++) tick();
        #2;
        rst_n = 1'b0;
        m_ph  = 0;
        m_hl  = 1'b0;
        #1;
        exp = model_out(m_ph, m_hl, op_r, zero_r);
        tests++;
        if (dut_vec !== exp) begin
            fails++;
            $display("FAIL reset_while_halted got=%b exp=%b", dut_vec, exp);
        end
        #1;
        rst_n = 1'b1;
        op_r  = 3'd2;
        tick();
        exp = model_out(m_ph, m_hl, op_r, zero_r);
        tests++;
        if (dut_vec !== exp) begin
            fails++;
            $display("FAIL restart_after_halt_reset got=%b exp=%b", dut_vec, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] exp;
        op_r = 3'd2;
        sync_to_phase0();
        op_r = 3'd6;
        for (int c = 0; c < 6; c++) tick();
        exp = model_out(m_ph, m_hl, op_r, zero_r);
        tests++;
        if (dut_vec !== exp) begin
            fails++;
            $display("FAIL sto_alu_op got=%b exp=%b", dut_vec, exp);
        end
        #2;
        rst_n = 1'b0;
        m_ph  = 0;
        m_hl  = 1'b0;
        #1;
        tests++;
        if (dut_vec !== 12'b000_1_0000_0000) begin
            fails++;
            $display("FAIL async_reset_mid got=%b exp=%b", dut_vec, 12'b000_1_0000_0000);
        end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            exp = model_out(m_ph, m_hl, op_r, zero_r);
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL post_reset_fetch ph=%0d got=%b exp=%b", m_ph, dut_vec, exp);
            end
        end
    endtask

    task automatic test_go_ignored();
        logic [11:0] exp;
        op_r = 3'd2;
        sync_to_phase0();
        go_r = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (m_ph == 0) op_r = 3'($urandom_range(1, 7));
            zero_r = 1'($urandom_range(0, 1));
            #1;
            exp = model_out(m_ph, m_hl, op_r, zero_r);
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL go_ignored ph=%0d got=%b exp=%b", m_ph, dut_vec, exp);
            end
            tick();
        end
        go_r = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] exp;
        for (int c = 0; c < 400; c++) begin
            if (m_ph == 0 || m_hl) op_r = 3'($urandom_range(0, 7));
            zero_r = 1'($urandom_range(0, 1));
            go_r   = ($urandom_range(0, 3) == 0);
            #1;
            exp = model_out(m_ph, m_hl, op_r, zero_r);
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL random c=%0d ph=%0d hl=%0d op=%0d got=%b exp=%b",
                         c, m_ph, m_hl, op_r, dut_vec, exp);
            end
            tick();
        end
        go_r = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add();
        test_skz();
        test_sto_jmp();
        test_halt();
        test_async_reset();
        test_go_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
